// File: rtl/cpu_hazard_pkg.sv
// Shared hazard-tracking definitions for the jr hazard controller.
// Contents:
//   resType_e  - result source codes carried by a decode-stage instruction
//   fwdSel_e   - jr target select codes driven on fwd_sel
//   slot_t     - one tracking entry {valid, waddr, tnew}
//   tnewOf     - cycles until a result of the given type becomes forwardable
//   tnewDec    - one pipeline advance of tnew, floored at zero
package cpu_hazard_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_PC8  = 2'd1,
    RES_ALU  = 2'd2,
    RES_LOAD = 2'd3
  } resType_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwdSel_e;

  // tnew seen on entry to E for each producing result type
  localparam logic [1:0] TNEW_PC8  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    logic [1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, waddr: 5'd0, tnew: 2'd0};

  function automatic logic [1:0] tnewOf(input logic [1:0] resType);
    logic [1:0] t;
    case (resType)
      RES_PC8:  t = TNEW_PC8;
      RES_ALU:  t = TNEW_ALU;
      RES_LOAD: t = TNEW_LOAD;
      default:  t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tnewDec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : (t - 2'd1);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline tracking register for the jr hazard controller.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (clears the entry)
//   hold        - freeze the entry, tnew included
//   bubble      - load an empty entry instead of slotIn
//   slotIn      - entry from the previous stage
//   slotOut     - current entry
// DEC_ON_LOAD selects whether tnew ages by one while moving into this slot;
// the E slot takes a fresh tnew from decode, later slots age the incoming one.
module hazard_slot
  import cpu_hazard_pkg::*;
#(
  parameter bit DEC_ON_LOAD = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  bubble,
  input  slot_t slotIn,
  output slot_t slotOut
);

  slot_t slot_r;

  // Slot register: reset beats hold, hold beats bubble, bubble beats shift
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_r <= SLOT_EMPTY;
    end else if (hold) begin
      slot_r <= slot_r;
    end else if (bubble) begin
      slot_r <= SLOT_EMPTY;
    end else begin
      slot_r.valid <= slotIn.valid;
      slot_r.waddr <= slotIn.waddr;
      slot_r.tnew  <= DEC_ON_LOAD ? tnewDec(slotIn.tnew) : slotIn.tnew;
    end
  end

  assign slotOut = slot_r;

endmodule

// File: rtl/jr_hazard_ctrl.sv
// jr hazard controller: tracks in-flight register writers in E, M and W and
// decides whether a decode-stage jr must stall or can take its target from a
// forwarding path.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   d_is_jr     - decode instruction is jr; d_rs is its source register
//   d_we, d_waddr, d_res_type - decode instruction's register write, if any
//   ext_stall   - freeze from another unit; tracking holds, counter holds
//   fwd_sel     - jr target select (regfile / E PC+8 / M result / W data)
//   stall       - jr must wait: hold PC and D, bubble into E
//   stall_cnt   - saturating count of cycles the jr actually stalled
module jr_hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_is_jr,
  input  logic [4:0]       d_rs,
  input  logic             d_we,
  input  logic [4:0]       d_waddr,
  input  logic [1:0]       d_res_type,
  input  logic             ext_stall,
  output logic [1:0]       fwd_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t            dEntry_s;
  slot_t            slotE_s;
  slot_t            slotM_s;
  slot_t            slotW_s;
  logic             matchE_s;
  logic             matchM_s;
  logic             matchW_s;
  logic             hit_s;
  logic [1:0]       hitTnew_s;
  fwdSel_e          hitSel_s;
  logic             stall_s;
  fwdSel_e          fwdSel_s;
  logic [CNT_W-1:0] stallCnt_r;

  // Decode entry; writes to $0 are never tracked since $0 cannot forward
  always_comb begin
    dEntry_s       = SLOT_EMPTY;
    dEntry_s.valid = d_we && (d_res_type != RES_NONE) && (d_waddr != 5'd0);
    dEntry_s.waddr = d_waddr;
    dEntry_s.tnew  = tnewOf(d_res_type);
  end

  hazard_slot #(.DEC_ON_LOAD(1'b0)) uSlotE (
    .clk     (clk),
    .reset   (reset),
    .hold    (ext_stall),
    .bubble  (stall_s),
    .slotIn  (dEntry_s),
    .slotOut (slotE_s)
  );

  hazard_slot #(.DEC_ON_LOAD(1'b1)) uSlotM (
    .clk     (clk),
    .reset   (reset),
    .hold    (ext_stall),
    .bubble  (1'b0),
    .slotIn  (slotE_s),
    .slotOut (slotM_s)
  );

  hazard_slot #(.DEC_ON_LOAD(1'b1)) uSlotW (
    .clk     (clk),
    .reset   (reset),
    .hold    (ext_stall),
    .bubble  (1'b0),
    .slotIn  (slotM_s),
    .slotOut (slotW_s)
  );

  assign matchE_s = slotE_s.valid && (slotE_s.waddr == d_rs) && (d_rs != 5'd0);
  assign matchM_s = slotM_s.valid && (slotM_s.waddr == d_rs) && (d_rs != 5'd0);
  assign matchW_s = slotW_s.valid && (slotW_s.waddr == d_rs) && (d_rs != 5'd0);

  // Youngest matching writer wins; an older match behind it is irrelevant
  always_comb begin
    hit_s     = 1'b0;
    hitTnew_s = 2'd0;
    hitSel_s  = FWD_RF;
    if (matchE_s) begin
      hit_s     = 1'b1;
      hitTnew_s = slotE_s.tnew;
      hitSel_s  = FWD_E;
    end else if (matchM_s) begin
      hit_s     = 1'b1;
      hitTnew_s = slotM_s.tnew;
      hitSel_s  = FWD_M;
    end else if (matchW_s) begin
      hit_s     = 1'b1;
      hitTnew_s = slotW_s.tnew;
      hitSel_s  = FWD_W;
    end else begin
      hit_s     = 1'b0;
    end
  end

  assign stall_s = d_is_jr && hit_s && (hitTnew_s != 2'd0);

  // Forward only once the value exists; a stalled jr reads nothing useful
  always_comb begin
    fwdSel_s = FWD_RF;
    if (d_is_jr && hit_s && !stall_s) begin
      fwdSel_s = hitSel_s;
    end else begin
      fwdSel_s = FWD_RF;
    end
  end

  // Stall statistics: counts only stalls that actually cost a cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && !ext_stall && (stallCnt_r != CNT_MAX)) begin
      stallCnt_r <= stallCnt_r + CNT_ONE;
    end else begin
      stallCnt_r <= stallCnt_r;
    end
  end

  assign stall     = stall_s;
  assign fwd_sel   = fwdSel_s;
  assign stall_cnt = stallCnt_r;

endmodule

// File: doc/jr_hazard_ctrl.md
JR_HAZARD_CTRL -- requirements
Module: jr_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the stall statistics counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 d_is_jr  input  1  decode-stage instruction is jr.
REQ-006 d_rs  input  5  jr source register address.
REQ-007 d_we  input  1  decode-stage instruction writes the register file.
REQ-008 d_waddr  input  5  decode-stage destination register; jal presents 31.
REQ-009 d_res_type  input  2  result source: 0 none, 1 PC+8 (jal), 2 ALU, 3 load.
REQ-010 ext_stall  input  1  pipeline freeze from another unit, e.g. mult busy.
REQ-011 fwd_sel  output  2  jr target select: 0 regfile, 1 E-stage PC+8, 2 M-stage result, 3 W-stage data.
REQ-012 stall  output  1  hold PC and D register, and inject a bubble into E.
REQ-013 stall_cnt  output  CNT_W  number of cycles in which jr stalled; saturating.

Function
REQ-014 The block SHALL hold three tracking slots E, M and W; each slot holds {valid, waddr, tnew[1:0]}.
REQ-015 On entry to E, tnew SHALL be 0 for type 1, 1 for type 2 and 2 for type 3; an entry is valid only if d_we=1, d_res_type!=0 and d_waddr!=0.
REQ-016 On each advancing edge, slots SHALL shift D->E->M->W and tnew SHALL decrement, saturating at 0; the old W entry is discarded.
REQ-017 A slot matches when valid=1, waddr==d_rs and d_rs!=0.
REQ-018 Only the youngest matching slot SHALL be considered, with priority E > M > W.
REQ-019 stall SHALL be 1, combinationally, when d_is_jr=1 and the youngest match has tnew>0.
REQ-020 fwd_sel SHALL be combinational: 0 when there is no match, d_is_jr=0, or stall=1; otherwise 1, 2 or 3 for a youngest match in E, M or W.
REQ-021 Slot rule for fwd_sel=1: it SHALL be produced only when the E slot matches with tnew=0, which holds only for type 1 (jal).
REQ-022 Slot rule for fwd_sel=2 and 3: an M-slot match gives 2 and a W-slot match gives 3, for any result type with tnew=0.
REQ-023 Cycle with stall=1 and ext_stall=0: E SHALL load an invalid bubble, M<=E and W<=M; the D-stage inputs are ignored.
REQ-024 Cycle with ext_stall=1: all slots SHALL hold their values, including tnew; stall_cnt does not increment; stall is still computed.
REQ-025 Cycle with ext_stall=0 and stall=0: normal shift per REQ-016.
REQ-026 stall_cnt SHALL increment on every cycle with stall=1 and ext_stall=0, saturating at all-ones with no wrap.
REQ-027 Latency: the jr resolves at most two stall cycles after a load in E, and at most one stall cycle after an ALU op in E.

Reset
REQ-028 While reset=1 at a clock edge, all slot valid bits SHALL clear to 0 and stall_cnt SHALL clear to 0, overriding ext_stall.
REQ-029 After reset, outputs SHALL be stall=0 and fwd_sel=0 regardless of D inputs.
REQ-030 Reset mid-stall SHALL abandon the pending hazard; tracking restarts from empty.

Structure
REQ-031 Result-type codes (NONE, PC8, ALU, LOAD), fwd_sel codes, and the tnew-per-type table SHALL live in a shared package, cpu_hazard_pkg.
REQ-032 A single sub-module, hazard_slot (one pipeline tracking register with tnew decrement, hold and bubble control), SHALL be instantiated three times.
REQ-033 There SHALL be no other sub-modules.

Verification
REQ-034 Scenario: jal (we=1, waddr=31, type 1), then next cycle jr $31 -> fwd_sel=1, stall=0.
REQ-035 Scenario: lw $5 (type 3), then jr $5 -> stall=1 for 2 cycles, then fwd_sel=3; stall_cnt=2.
REQ-036 Scenario: addu $8 (type 2), then jr $8 -> 1 stall cycle, then fwd_sel=2.
REQ-037 Scenario: a writer to $0 followed by jr $0 -> stall=0 and fwd_sel=0; a jr $9 with no in-flight writer -> fwd_sel=0.
REQ-038 Scenario: addu $4 in E and lw $4 in M -> E has priority and gives stall=1, and the M match is ignored; ext_stall=1 during the stall -> slots frozen and stall_cnt unchanged.
REQ-039 Scenario: preload stall_cnt to all-ones via repeated stalls, then stall again -> stall_cnt remains all-ones; reset asserted mid-stall -> next cycle stall=0, stall_cnt=0.
